weight_port_arbiter: RTL and testbench

- Shares the single weight_store read port (6-bit tensor select, 16-bit address, 8-bit data, 1-cycle registered read latency) among NUM_REQ compute blocks (embedding, attention, mlp, lm_head).
- Round-robin arbitration per beat; a requester may lock the port for a burst.
- Read data is returned to the issuing requester with a registered valid exactly one cycle after its grant.

---
 rtl/weight_port_arbiter_pkg.sv | 29 ++
 rtl/weight_port_arbiter_rr_arbiter.sv | 36 +++
 rtl/weight_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_weight_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_port_arbiter_pkg.sv
// Shared weight_store definitions: default port widths, tensor selects,
// arbiter state encodings and index-width helper.
package weight_port_arbiter_pkg;

  localparam int DEF_SEL_W  = 6;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [5:0] {
    TOK_EMB  = 6'd0,
    POS_EMB  = 6'd1,
    ATTN_QKV = 6'd2,
    ATTN_OUT = 6'd3,
    LN1_GAIN = 6'd4,
    MLP_FC   = 6'd5,
    MLP_PROJ = 6'd6,
    LN2_GAIN = 6'd7,
    LNF_GAIN = 6'd8,
    LM_HEAD  = 6'd9
  } tensor_sel_e;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: rotate requests by the pointer, isolate the
// lowest set bit, rotate back. Also reports the winner index.
module rr_arbiter
  import weight_port_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   pick;

  always_comb begin
    req_dbl = {req_i, req_i} >> ptr_i;
    rot     = req_dbl[N-1:0];
    // two's-complement trick keeps only the lowest set bit
    pick    = rot & (~rot + N'(1));
    gnt_dbl = {pick, pick} << ptr_i;
    gnt_o   = gnt_dbl[2*N-1:N];
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_o[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/weight_port_arbiter.sv
// Round-robin arbiter with burst lock for the shared weight_store read port.
// Optional per-requester stall counters: define WEIGHT_ARB_STALL_CNT_EN.
module weight_port_arbiter
  import weight_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [SEL_W-1:0]          w_sel_o,
  output logic [ADDR_W-1:0]         w_addr_o,
  input  logic [DATA_W-1:0]         w_data_i,
  output logic                      busy_o,
  output logic [NUM_REQ*16-1:0]     stall_cnt_o
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_any;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel_q, sel_mux;
  logic [ADDR_W-1:0]  addr_q, addr_mux;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) >= NUM_REQ - 1) return '0;
    return i + IDX_W'(1);
  endfunction

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    gnt      = '0;
    if (state_q == ST_IDLE) begin
      gnt = rr_gnt;
      if (rr_any) begin
        if (lock_i[rr_idx]) begin
          state_d = ST_LOCKED;
          owner_d = rr_idx;
        end else begin
          rr_ptr_d = next_idx(rr_idx);
        end
      end
    end else begin
      // owner keeps the port; a dropped req with lock held is a bubble
      gnt = req_i & (NUM_REQ'(1) << owner_q);
      if (!lock_i[owner_q]) begin
        state_d  = ST_IDLE;
        rr_ptr_d = next_idx(owner_q);
      end
    end
  end

  assign gnt_o = rst_ni ? gnt : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= gnt_o & req_i;
    end
  end

  always_comb begin
    sel_mux  = sel_q;
    addr_mux = addr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_o[k]) begin
        sel_mux  = req_sel_i[k*SEL_W +: SEL_W];
        addr_mux = req_addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // Address is held without a grant so the BRAM inputs stay quiet.
  always_ff @(posedge clk_i) begin
    if (|gnt_o) begin
      sel_q  <= sel_mux;
      addr_q <= addr_mux;
    end
  end

  assign w_sel_o  = sel_mux;
  assign w_addr_o = addr_mux;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = w_data_i;
  assign busy_o   = (state_q == ST_LOCKED);

`ifdef WEIGHT_ARB_STALL_CNT_EN
  logic [NUM_REQ*16-1:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_i[k] && !gnt_o[k] && (stall_q[k*16 +: 16] != 16'hFFFF))
          stall_q[k*16 +: 16] <= stall_q[k*16 +: 16] + 16'd1;
      end
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_weight_port_arbiter.sv
// Directed bench for weight_port_arbiter: vector table plus burst, bubble,
// reset and stall-counter sequences against a weight_store model.
module tb_weight_port_arbiter;

  localparam int NR = 4;
  localparam int SW = 6;
  localparam int AW = 16;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    lock = '0;
  logic [NR*SW-1:0] req_sel = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata;
  logic [DW-1:0]    w_data = '0;
  logic [SW-1:0]    w_sel;
  logic [AW-1:0]    w_addr;
  logic             busy;
  logic [NR*16-1:0] stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [5:0]  sel;
    logic [15:0] addr;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  weight_port_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .lock_i      (lock),
    .req_sel_i   (req_sel),
    .req_addr_i  (req_addr),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .w_sel_o     (w_sel),
    .w_addr_o    (w_addr),
    .w_data_i    (w_data),
    .busy_o      (busy),
    .stall_cnt_o (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] wmem(input logic [5:0] s, input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ ({2'b00, s} * 8'd37);
  endfunction

  // weight_store model: one-cycle registered read
  always @(posedge clk) w_data <= wmem(w_sel, w_addr);

  function automatic logic [5:0] fsel(input int k, input logic [5:0] s);
    return s ^ 6'(k);
  endfunction

  function automatic logic [15:0] faddr(input int k, input logic [15:0] a);
    return a ^ (16'(k) << 12);
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l,
                       input logic [5:0] s, input logic [15:0] a);
    req  = r;
    lock = l;
    for (int k = 0; k < NR; k++) begin
      req_sel[k*SW +: SW]  = fsel(k, s);
      req_addr[k*AW +: AW] = faddr(k, a);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(4'b0000, 4'b0000, 6'd0, 16'd0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic void add(input logic [3:0] r, input logic [3:0] l, input logic [5:0] s,
                              input logic [15:0] a, input logic [3:0] g, input logic [3:0] rv,
                              input logic b);
    vec_t v;
    v.req = r; v.lock = l; v.sel = s; v.addr = a; v.gnt = g; v.rv = rv; v.busy = b;
    tbl.push_back(v);
  endfunction

  logic [5:0]  hold_sel;
  logic [15:0] hold_addr;
  logic [7:0]  exp_data;
  logic        have_hold;
  logic [3:0]  prev_g;
  logic [15:0] a_cur;
  logic [15:0] stall_exp;

  initial begin
    //   req      lock     sel   addr      gnt      rv       busy
    add(4'b0111, 4'b0000, 6'd2, 16'h0100, 4'b0001, 4'b0000, 1'b0);
    add(4'b0111, 4'b0000, 6'd3, 16'h0101, 4'b0010, 4'b0001, 1'b0);
    add(4'b0111, 4'b0000, 6'd4, 16'h0102, 4'b0100, 4'b0010, 1'b0);
    add(4'b0111, 4'b0000, 6'd5, 16'h0103, 4'b0001, 4'b0100, 1'b0);
    add(4'b0111, 4'b0000, 6'd6, 16'h0104, 4'b0010, 4'b0001, 1'b0);
    add(4'b0111, 4'b0000, 6'd7, 16'h0105, 4'b0100, 4'b0010, 1'b0);
    add(4'b0000, 4'b0000, 6'd8, 16'h0106, 4'b0000, 4'b0100, 1'b0);
    add(4'b1001, 4'b0000, 6'd9, 16'h0107, 4'b1000, 4'b0000, 1'b0);
    add(4'b1001, 4'b0000, 6'd2, 16'h0108, 4'b0001, 4'b1000, 1'b0);
    add(4'b1010, 4'b0000, 6'd3, 16'h0109, 4'b0010, 4'b0001, 1'b0);
    add(4'b1010, 4'b0000, 6'd4, 16'h010A, 4'b1000, 4'b0010, 1'b0);
    add(4'b0001, 4'b0000, 6'd1, 16'h0005, 4'b0001, 4'b1000, 1'b0);
    add(4'b0000, 4'b0000, 6'd5, 16'h0200, 4'b0000, 4'b0001, 1'b0);
    add(4'b0100, 4'b0100, 6'd6, 16'h0201, 4'b0100, 4'b0000, 1'b0);
    add(4'b0101, 4'b0100, 6'd7, 16'h0202, 4'b0100, 4'b0100, 1'b1);
    add(4'b0001, 4'b0100, 6'd8, 16'h0203, 4'b0000, 4'b0100, 1'b1);
    add(4'b0101, 4'b0000, 6'd9, 16'h0204, 4'b0100, 4'b0000, 1'b1);
    add(4'b0101, 4'b0000, 6'd2, 16'h0205, 4'b0001, 4'b0100, 1'b0);
    add(4'b0010, 4'b0010, 6'd3, 16'h0206, 4'b0010, 4'b0001, 1'b0);
    add(4'b0000, 4'b0000, 6'd4, 16'h0207, 4'b0000, 4'b0010, 1'b1);
    add(4'b1010, 4'b0000, 6'd5, 16'h0208, 4'b1000, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 6'd6, 16'h0209, 4'b0000, 4'b1000, 1'b0);

    // Reset held with requests pending: no grant, outputs cleared.
    drive(4'b1111, 4'b0000, 6'd0, 16'd0);
    tick();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    tick();
    rst_n = 1'b1;

    have_hold = 1'b0;
    exp_data  = '0;
    hold_sel  = '0;
    hold_addr = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].lock, tbl[i].sel, tbl[i].addr);
      #1;
      chk($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
      chk($sformatf("tbl%0d_rvalid", i), 64'(rvalid), 64'(tbl[i].rv));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
      if (tbl[i].rv != 4'b0000)
        chk($sformatf("tbl%0d_rdata", i), 64'(rdata), 64'(exp_data));
      if (tbl[i].gnt != 4'b0000) begin
        hold_sel  = fsel(oh_idx(tbl[i].gnt), tbl[i].sel);
        hold_addr = faddr(oh_idx(tbl[i].gnt), tbl[i].addr);
        exp_data  = wmem(hold_sel, hold_addr);
        have_hold = 1'b1;
      end
      if (have_hold) begin
        chk($sformatf("tbl%0d_wsel", i), 64'(w_sel), 64'(hold_sel));
        chk($sformatf("tbl%0d_waddr", i), 64'(w_addr), 64'(hold_addr));
      end
      tick();
    end

    // 128-beat locked burst by requester 1 with requester 3 waiting.
    do_reset();
    for (int b = 0; b < 128; b++) begin
      drive(4'b1010, (b < 127) ? 4'b0010 : 4'b0000, 6'd1, 16'(b) ^ 16'h1000);
      #1;
      chk($sformatf("burst%0d_gnt", b), 64'(gnt), 64'h2);
      chk($sformatf("burst%0d_busy", b), 64'(busy), (b > 0) ? 64'h1 : 64'h0);
      chk($sformatf("burst%0d_waddr", b), 64'(w_addr), 64'(b));
      chk($sformatf("burst%0d_wsel", b), 64'(w_sel), 64'h0);
      chk($sformatf("burst%0d_rvalid", b), 64'(rvalid), (b > 0) ? 64'h2 : 64'h0);
      if (b > 0) chk($sformatf("burst%0d_rdata", b), 64'(rdata), 64'(wmem(6'd0, 16'(b - 1))));
      tick();
    end
    // rr_ptr must now be 2, so 3 beats 0.
    drive(4'b1001, 4'b0000, 6'd0, 16'h0000);
    #1;
    chk("post_burst_gnt", 64'(gnt), 64'h8);
    chk("post_burst_busy", 64'(busy), 64'h0);
    chk("post_burst_rvalid", 64'(rvalid), 64'h2);
    chk("post_burst_rdata", 64'(rdata), 64'(wmem(6'd0, 16'd127)));
    tick();
    drive(4'b0000, 4'b0000, 6'd0, 16'h0000);
    #1;
    chk("post_burst_rvalid3", 64'(rvalid), 64'h8);

    // Lock owner 0 bubbles for 3 cycles while requester 2 waits.
    do_reset();
    a_cur  = 16'h0020;
    prev_g = 4'b0000;
    for (int c = 0; c < 7; c++) begin
      logic r0;
      r0 = (c < 2) || (c > 4);
      drive({2'b01, 1'b0, r0}, (c < 6) ? 4'b0001 : 4'b0000, 6'd3, a_cur);
      #1;
      chk($sformatf("bub%0d_gnt", c), 64'(gnt), r0 ? 64'h1 : 64'h0);
      chk($sformatf("bub%0d_busy", c), 64'(busy), (c > 0) ? 64'h1 : 64'h0);
      chk($sformatf("bub%0d_rvalid", c), 64'(rvalid), 64'(prev_g));
      if (prev_g != 4'b0000)
        chk($sformatf("bub%0d_rdata", c), 64'(rdata), 64'(wmem(6'd3, a_cur - 16'd1)));
      chk($sformatf("bub%0d_waddr", c), 64'(w_addr), r0 ? 64'(a_cur) : 64'(a_cur - 16'd1));
      prev_g = r0 ? 4'b0001 : 4'b0000;
      tick();
      if (r0) a_cur = a_cur + 16'd1;
    end
    drive(4'b0101, 4'b0000, 6'd3, a_cur);
    #1;
    chk("bub_after_gnt", 64'(gnt), 64'h4);
    chk("bub_after_rdata", 64'(rdata), 64'(wmem(6'd3, 16'h0023)));
    tick();

    // Asynchronous reset in the middle of a locked burst.
    do_reset();
    drive(4'b0100, 4'b0100, 6'd0, 16'h0300);
    tick();
    drive(4'b0100, 4'b0100, 6'd0, 16'h0301);
    tick();
    chk("pre_rst_rvalid", 64'(rvalid), 64'h4);
    chk("pre_rst_busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 64'(gnt), 64'h0);
    chk("mid_rst_rvalid", 64'(rvalid), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(4'b1111, 4'b0000, 6'd0, 16'h0000);
    #1;
    chk("restart_gnt0", 64'(gnt), 64'h1);
    chk("restart_busy", 64'(busy), 64'h0);
    tick();
    chk("restart_gnt1", 64'(gnt), 64'h2);
    chk("restart_rvalid", 64'(rvalid), 64'h1);
    tick();

    // Requester 2 waits 5 cycles behind requester 0's lock.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(4'b0101, (c < 4) ? 4'b0001 : 4'b0000, 6'd0, 16'h0400);
      #1;
      chk($sformatf("stall%0d_gnt", c), 64'(gnt), 64'h1);
      tick();
    end
    drive(4'b0100, 4'b0000, 6'd0, 16'h0400);
    #1;
    chk("stall_release_gnt", 64'(gnt), 64'h4);
    tick();
    drive(4'b0000, 4'b0000, 6'd0, 16'h0000);
`ifdef WEIGHT_ARB_STALL_CNT_EN
    stall_exp = 16'd5;
`else
    stall_exp = 16'd0;
`endif
    chk("stall_cnt2", 64'(stall[2*16 +: 16]), 64'(stall_exp));
    chk("stall_cnt0", 64'(stall[0 +: 16]), 64'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
